conv3x3_pe: RTL and testbench

CONV3X3_PE -- requirements
Module: conv3x3_pe

---
 rtl/conv3x3_pe_if.sv | 57 +++++
 rtl/conv3x3_pe.sv | 247 ++++++++++++++++++++++++
 tb/tb_conv3x3_pe.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_pe_if.sv
// ---------------------------------------------------------------------------
// conv3x3_pe_if
//
// Bundles the weight-load, window-input and pixel-output signals of the
// 3x3 convolution processing element so they travel as one port.
//
// Signals
//   w_load      weight/bias write strobe, one value per cycle
//   w_data      signed 8-bit weight/bias value, sampled with w_load
//   w_ready     high once all nine weights and the bias are loaded
//   in_valid    a 3x3 window is presented this cycle (no backpressure)
//   win         nine unsigned 8-bit taps, tap k at win[8k+7:8k]
//   out_valid   pix_out carries a new result this cycle
//   pix_out     unsigned 8-bit quantized convolution result
//   frame_done  one-cycle pulse with the last out_valid of a frame
//
// Handshake semantics: there is no ready on the window path. A window is
// consumed on any rising edge where in_valid=1, w_ready=1 and w_load=0;
// every other window is silently dropped. out_valid is a one-cycle
// qualifier for pix_out and the sink must accept it unconditionally.
//
// Modports
//   master  upstream/downstream environment (drives loads and windows)
//   slave   the processing element
// ---------------------------------------------------------------------------
interface conv3x3_pe_if;
  logic              w_load;
  logic signed [7:0] w_data;
  logic              w_ready;
  logic              in_valid;
  logic [71:0]       win;
  logic              out_valid;
  logic [7:0]        pix_out;
  logic              frame_done;

  modport master (
    output w_load,
    output w_data,
    output in_valid,
    output win,
    input  w_ready,
    input  out_valid,
    input  pix_out,
    input  frame_done
  );

  modport slave (
    input  w_load,
    input  w_data,
    input  in_valid,
    input  win,
    output w_ready,
    output out_valid,
    output pix_out,
    output frame_done
  );
endinterface

// File: rtl/conv3x3_pe.sv
// ---------------------------------------------------------------------------
// conv3x3_pe
//
// 3x3 convolution processing element. Nine signed 8-bit weights and a
// signed 8-bit bias are loaded serially; afterwards one 3x3 window of
// unsigned 8-bit taps is accepted per cycle and produces one unsigned
// 8-bit pixel exactly four cycles later.
//
// Parameters
//   IMG_WIDTH  output pixels per frame side (frame = IMG_WIDTH^2 outputs)
//   SHIFT      arithmetic right shift applied before output saturation
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus        conv3x3_pe_if.slave (load, window and output signals)
//   state_dbg  current controller state: 0 = LOAD, 1 = RUN
//
// Pipeline (window accepted at edge N)
//   edge N    capture: taps, weights and bias snapshot
//   edge N+1  nine 17-bit signed products
//   edge N+2  three row partial sums
//   edge N+3  20-bit accumulator including bias
//   edge N+4  clamp/shift into pix_out, out_valid, frame_done
// ---------------------------------------------------------------------------
module conv3x3_pe #(
  parameter int IMG_WIDTH = 128,
  parameter int SHIFT     = 4
) (
  input  logic          clk,
  input  logic          rst,
  conv3x3_pe_if.slave   bus,
  output logic          state_dbg
);

  localparam int FRAME_PIX = IMG_WIDTH * IMG_WIDTH;
  localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIX - 1);
  localparam logic [3:0] BIAS_IDX = 4'd9;

  // -------------------------------------------------------------------------
  // Load/run controller
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       wr_en;
  logic [3:0] wr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.w_load) begin
          wr_en  = 1'b1;
          wr_idx = idx_q;
          if (idx_q == BIAS_IDX) begin
            state_d = ST_RUN;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_RUN: begin
        // A write while running restarts the whole load sequence; the
        // written value becomes w0 immediately.
        if (bus.w_load) begin
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          state_d = ST_LOAD;
          idx_d   = 4'd1;
        end
      end
      default: begin
        state_d = ST_LOAD;
        idx_d   = 4'd0;
      end
    endcase
  end

  assign bus.w_ready = (state_q == ST_RUN);
  assign state_dbg   = (state_q == ST_RUN);

  // -------------------------------------------------------------------------
  // Weight and bias storage
  // -------------------------------------------------------------------------
  logic signed [7:0] w_q [9];
  logic signed [7:0] bias_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) w_q[k] <= 8'sd0;
      bias_q <= 8'sd0;
    end else if (wr_en) begin
      if (wr_idx == BIAS_IDX) bias_q <= bus.w_data;
      for (int k = 0; k < 9; k++) begin
        if (wr_idx == 4'(k)) w_q[k] <= bus.w_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Capture stage. Weights and bias are snapshotted with the taps so a
  // reload after acceptance cannot disturb a window already accepted.
  // -------------------------------------------------------------------------
  logic              cap;
  logic              c_v;
  logic [7:0]        c_tap [9];
  logic signed [7:0] c_w   [9];
  logic signed [7:0] c_bias;

  assign cap = (state_q == ST_RUN) && bus.in_valid && !bus.w_load;

  always_ff @(posedge clk) begin
    if (rst) c_v <= 1'b0;
    else     c_v <= cap;
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      for (int k = 0; k < 9; k++) begin
        c_tap[k] <= bus.win[8*k +: 8];
        c_w[k]   <= w_q[k];
      end
      c_bias <= bias_q;
    end
  end

  // -------------------------------------------------------------------------
  // Product stage: zero-extended tap times signed weight. The 17-bit
  // result holds the full range 255 * -128 .. 255 * 127.
  // -------------------------------------------------------------------------
  logic signed [16:0] prod_c [9];
  logic signed [16:0] p_q    [9];
  logic signed [7:0]  p_bias;
  logic               p_v;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_c[k] = 17'($signed({1'b0, c_tap[k]})) * 17'(c_w[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) p_v <= 1'b0;
    else     p_v <= c_v;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 9; k++) p_q[k] <= prod_c[k];
    p_bias <= c_bias;
  end

  // -------------------------------------------------------------------------
  // Partial-sum stage: one sum per window row.
  // -------------------------------------------------------------------------
  logic signed [18:0] ps_q [3];
  logic signed [7:0]  s_bias;
  logic               s_v;

  always_ff @(posedge clk) begin
    if (rst) s_v <= 1'b0;
    else     s_v <= p_v;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      ps_q[r] <= 19'(p_q[3*r]) + 19'(p_q[3*r+1]) + 19'(p_q[3*r+2]);
    end
    s_bias <= p_bias;
  end

  // -------------------------------------------------------------------------
  // Accumulator stage: 20 bits cover 9 * 32640 + 128 in magnitude.
  // -------------------------------------------------------------------------
  logic signed [19:0] acc_q;
  logic               a_v;

  always_ff @(posedge clk) begin
    if (rst) a_v <= 1'b0;
    else     a_v <= s_v;
  end

  always_ff @(posedge clk) begin
    acc_q <= 20'(ps_q[0]) + 20'(ps_q[1]) + 20'(ps_q[2]) + 20'(s_bias);
  end

  // -------------------------------------------------------------------------
  // Output stage: negative clamps to 0, shifted value saturates at 255.
  // -------------------------------------------------------------------------
  logic signed [19:0] shifted;
  logic [7:0]         quant;

  always_comb begin
    shifted = acc_q >>> SHIFT;
    quant   = shifted[7:0];
    if (acc_q < 20'sd0) begin
      quant = 8'd0;
    end else if (shifted > 20'sd255) begin
      quant = 8'hFF;
    end
  end

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.pix_out    <= 8'd0;
      bus.frame_done <= 1'b0;
      cnt_q          <= '0;
    end else begin
      bus.out_valid  <= a_v;
      bus.frame_done <= 1'b0;
      if (a_v) begin
        bus.pix_out <= quant;
        // The counter only advances on outputs, so weight reloads leave
        // the frame position untouched.
        if (cnt_q == CNT_LAST) begin
          cnt_q          <= '0;
          bus.frame_done <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_pe.sv
// ---------------------------------------------------------------------------
// tb_conv3x3_pe
//
// Self-checking bench for conv3x3_pe with a 4x4 frame. Stimulus tasks
// drive the interface on falling edges and push the expected pixel,
// frame_done flag and arrival cycle into exp_q; a monitor on falling
// edges pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_conv3x3_pe;
  localparam int IMG_WIDTH = 4;
  localparam int SHIFT     = 4;
  localparam int FRAME     = IMG_WIDTH * IMG_WIDTH;
  localparam int W         = 41;  // {arrival cycle[31:0], frame_done, pix[7:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv3x3_pe_if bus ();
  logic state_dbg;

  conv3x3_pe #(.IMG_WIDTH(IMG_WIDTH), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;
  logic [7:0] last_pix = 8'd0;

  // reference model of the weight memory and frame position
  int mw [10];
  int m_idx    = 0;
  bit m_run    = 1'b0;
  int m_outcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_pix(input logic [71:0] w);
    int acc;
    acc = mw[9];
    for (int k = 0; k < 9; k++) acc += int'(w[8*k +: 8]) * mw[k];
    if (acc < 0) return 8'd0;
    acc = acc / (1 << SHIFT);
    if (acc > 255) return 8'd255;
    return acc[7:0];
  endfunction

  function automatic logic [71:0] rand_win();
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  function automatic void model_write(input logic [7:0] d);
    if (!m_run) begin
      mw[m_idx] = int'($signed(d));
      if (m_idx == 9) begin
        m_run = 1'b1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else begin
      m_run = 1'b0;
      mw[0] = int'($signed(d));
      m_idx = 1;
    end
  endfunction

  // driver: one clock cycle of stimulus
  task automatic step(input logic wl, input logic [7:0] wd, input logic iv, input logic [71:0] wv);
    logic fd;
    logic [7:0] px;
    @(negedge clk);
    check("w_ready", bus.w_ready, m_run);
    bus.w_load   = wl;
    bus.w_data   = wd;
    bus.in_valid = iv;
    bus.win      = wv;
    if (iv && !wl && m_run) begin
      px = ref_pix(wv);
      fd = (m_outcnt == FRAME - 1);
      m_outcnt = (m_outcnt + 1) % FRAME;
      // accepted at the coming edge (cyc+1), visible four edges later
      exp_q.push_back({cyc + 32'd5, fd, px});
    end
    if (wl) model_write(wd);
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 1'b0, 72'd0);
  endtask

  task automatic window(input logic [71:0] wv);
    step(1'b0, 8'd0, 1'b1, wv);
  endtask

  task automatic load_const(input int wv, input int b);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(wv), 1'b0, 72'd0);
    step(1'b1, 8'(b), 1'b0, 72'd0);
  endtask

  task automatic load_rand();
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 72'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      idle();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    idle();
    idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.w_load   = 1'b0;
    bus.w_data   = 8'd0;
    bus.in_valid = 1'b0;
    bus.win      = 72'd0;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_pix = 8'd0;
    for (int i = 0; i < 10; i++) mw[i] = 0;
    m_idx    = 0;
    m_run    = 1'b0;
    m_outcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pix_out", bus.pix_out, 0);
    check("rst_frame_done", bus.frame_done, 0);
    armed = 1'b1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (armed) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1 pix=%0d expected no output (t=%0t)",
                   bus.pix_out, $time);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("pix_out", bus.pix_out, e[7:0]);
          check("frame_done", bus.frame_done, e[8]);
          check("latency_cycle", cyc, e[40:9]);
          last_pix = e[7:0];
        end
      end else begin
        check("pix_hold", bus.pix_out, last_pix);
        check("frame_done_idle", bus.frame_done, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.w_load   = 1'b0;
    bus.w_data   = 8'd0;
    bus.in_valid = 1'b0;
    bus.win      = 72'd0;
    do_reset();

    // unit weights, taps 16 -> 144 >> 4 = 9
    load_const(1, 0);
    idle();
    window({9{8'd16}});
    drain();

    // all -1, taps 10 -> negative accumulator clamps to 0
    load_const(-1, 0);
    window({9{8'd10}});
    drain();

    // maximum positive -> saturates at 255
    load_const(127, 127);
    window({9{8'd255}});
    drain();

    // partial load: windows are ignored, w_ready stays low
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 72'd0);
    for (int i = 0; i < 4; i++) window(rand_win());
    for (int i = 0; i < 6; i++) idle();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 72'd0);
    window(rand_win());
    // w_load coincident with in_valid in RUN: window dropped, back to LOAD
    step(1'b1, 8'd3, 1'b1, rand_win());
    idle();
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 72'd0);
    window(rand_win());
    drain();

    // frame boundary: 17 back-to-back windows after a clean reset
    do_reset();
    load_rand();
    for (int i = 0; i < 17; i++) window(rand_win());
    drain();

    // randomized traffic with occasional mid-stream reloads
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (!m_run) step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), rand_win());
      else if (r < 3) step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), rand_win());
      else if (r < 75) window(rand_win());
      else idle();
    end
    drain();

    // reset with three windows in flight: nothing may emerge
    load_rand();
    for (int i = 0; i < 3; i++) window(rand_win());
    do_reset();
    for (int i = 0; i < 10; i++) idle();
    check("post_rst_pix_out", bus.pix_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
